// File: rtl/lab3_cache_pkg.sv
// -----------------------------------------------------------------------------
// lab3_cache_pkg
// Shared constants and types for the lab3 cache memory-side sender.
//   WORD_BITS : width of one serialized word
//   NWORDS    : words per cache line
//   LINE_BITS : width of a full cache line
//   CNT_BITS  : width of the word counter
//   sender_state_e : two-state sender FSM encoding (IDLE, SEND)
// -----------------------------------------------------------------------------
package lab3_cache_pkg;

   localparam int WORD_BITS = 32;
   localparam int NWORDS    = 16;
   localparam int LINE_BITS = WORD_BITS * NWORDS;
   localparam int CNT_BITS  = $clog2(NWORDS);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } sender_state_e;

endpackage : lab3_cache_pkg

// File: rtl/lab3_cache_cache_mem_sender.sv
// -----------------------------------------------------------------------------
// lab3_cache_cache_mem_sender
// Accepts a full cache line on a valid/ready input stream, latches it, and
// serializes it word 0 first onto a valid/ready output stream.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : asynchronous active-low reset
//   istream_val    : upstream presents a line on line_data
//   istream_rdy    : sender can accept a line
//   line_data      : line to serialize, word i at [WORD_BITS*i +: WORD_BITS]
//   ostream_val    : cache_req_msg holds a valid word
//   ostream_rdy    : downstream accepts the current word
//   cache_req_msg  : current word
//   ostream_last   : current word is the last word of the line
//
// Configuration
//   LAB3_CACHE_MEM_SENDER_BACK2BACK_EN : when defined, a new line may be
//   accepted on the cycle the last word of the current line transfers, so
//   lines stream with no idle bubble. Undefined (default): one idle cycle
//   between lines and istream_rdy depends on state only.
// -----------------------------------------------------------------------------
module lab3_cache_cache_mem_sender #(
   parameter int WORD_BITS = lab3_cache_pkg::WORD_BITS,
   parameter int NWORDS    = lab3_cache_pkg::NWORDS
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          istream_val,
   output logic                          istream_rdy,
   input  logic [WORD_BITS*NWORDS-1:0]   line_data,
   output logic                          ostream_val,
   input  logic                          ostream_rdy,
   output logic [WORD_BITS-1:0]          cache_req_msg,
   output logic                          ostream_last
);

   import lab3_cache_pkg::*;

   localparam int                LBITS    = WORD_BITS * NWORDS;
   localparam int                CBITS    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CBITS-1:0]  LAST_IDX = CBITS'(NWORDS - 1);
   localparam logic [CBITS-1:0]  CNT_ONE  = CBITS'(1);

   sender_state_e       state_r;
   logic [CBITS-1:0]    cnt_r;
   logic [LBITS-1:0]    line_r;
   logic                rdy_r;
   logic                val_r;
   logic                last_r;

   logic                xfer_s;
   logic                last_xfer_s;
   logic                accept_s;

   assign xfer_s      = val_r & ostream_rdy;
   assign last_xfer_s = xfer_s & last_r;
   assign accept_s    = istream_val & istream_rdy;

   // rdy_r is held low during reset and only rises on the first clock after
   // release, so istream_rdy reads 0 while reset is asserted even though the
   // FSM already sits in IDLE.
`ifdef LAB3_CACHE_MEM_SENDER_BACK2BACK_EN
   assign istream_rdy = rdy_r | last_xfer_s;
`else
   assign istream_rdy = rdy_r;
`endif

   assign ostream_val  = val_r;
   assign ostream_last = last_r;

   // Word mux driven purely from registers; zero when nothing is presented.
   assign cache_req_msg = val_r ? line_r[int'(cnt_r)*WORD_BITS +: WORD_BITS]
                                : {WORD_BITS{1'b0}};

   // Sender FSM: line register, word counter and registered handshake flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         cnt_r   <= {CBITS{1'b0}};
         line_r  <= {LBITS{1'b0}};
         rdy_r   <= 1'b0;
         val_r   <= 1'b0;
         last_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  line_r  <= line_data;
                  cnt_r   <= {CBITS{1'b0}};
                  state_r <= SEND;
                  val_r   <= 1'b1;
                  rdy_r   <= 1'b0;
                  last_r  <= (LAST_IDX == {CBITS{1'b0}});
               end else begin
                  rdy_r   <= 1'b1;
                  val_r   <= 1'b0;
                  last_r  <= 1'b0;
               end
            end
            SEND: begin
               if (xfer_s) begin
                  if (last_r) begin
                     // accept_s can only be high here in the back-to-back build.
                     if (accept_s) begin
                        line_r  <= line_data;
                        cnt_r   <= {CBITS{1'b0}};
                        state_r <= SEND;
                        val_r   <= 1'b1;
                        rdy_r   <= 1'b0;
                        last_r  <= (LAST_IDX == {CBITS{1'b0}});
                     end else begin
                        cnt_r   <= {CBITS{1'b0}};
                        state_r <= IDLE;
                        val_r   <= 1'b0;
                        rdy_r   <= 1'b1;
                        last_r  <= 1'b0;
                     end
                  end else begin
                     cnt_r  <= cnt_r + CNT_ONE;
                     last_r <= ((cnt_r + CNT_ONE) == LAST_IDX);
                  end
               end else begin
                  // Downstream stalled: counter and flags hold so the word is stable.
                  cnt_r  <= cnt_r;
                  last_r <= last_r;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CBITS{1'b0}};
               rdy_r   <= 1'b0;
               val_r   <= 1'b0;
               last_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule : lab3_cache_cache_mem_sender

// File: tb/tb_lab3_cache_cache_mem_sender.sv
// -----------------------------------------------------------------------------
// tb_lab3_cache_cache_mem_sender
// Self-checking bench: a queue of expected words models the sender; every
// cycle the DUT outputs are compared with the queue head.
// -----------------------------------------------------------------------------
module tb_lab3_cache_cache_mem_sender;

   localparam int WB = 32;
   localparam int NW = 16;
   localparam int LB = WB * NW;

   logic           clk;
   logic           reset;
   logic           istream_val;
   logic           istream_rdy;
   logic [LB-1:0]  line_data;
   logic           ostream_val;
   logic           ostream_rdy;
   logic [WB-1:0]  cache_req_msg;
   logic           ostream_last;

   lab3_cache_cache_mem_sender #(.WORD_BITS(WB), .NWORDS(NW)) dut (
      .clk           (clk),
      .reset         (reset),
      .istream_val   (istream_val),
      .istream_rdy   (istream_rdy),
      .line_data     (line_data),
      .ostream_val   (ostream_val),
      .ostream_rdy   (ostream_rdy),
      .cache_req_msg (cache_req_msg),
      .ostream_last  (ostream_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WB-1:0] word;
      logic          last;
   } exp_t;

   exp_t          exp_q[$];
   logic [WB-1:0] obs_q[$];
   int            xc_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            acc_cnt  = 0;
   int            cyc      = 0;
   int            val_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [LB-1:0] mk_line(input logic [WB-1:0] base, input logic [WB-1:0] step);
      logic [LB-1:0] l;
      for (int i = 0; i < NW; i++) l[WB*i +: WB] = base + step * WB'(i);
      return l;
   endfunction

   function automatic logic [LB-1:0] rnd_line();
      logic [LB-1:0] l;
      for (int i = 0; i < NW; i++) l[WB*i +: WB] = $urandom;
      return l;
   endfunction

   // One clock cycle: drive inputs at the negedge, check, update the model.
   task automatic cycle(input logic ival, input logic [LB-1:0] ldata, input logic ordy);
      logic exp_val, exp_rdy;
      istream_val = ival;
      line_data   = ldata;
      ostream_rdy = ordy;
      #1;
      exp_val = (exp_q.size() != 0);
`ifdef LAB3_CACHE_MEM_SENDER_BACK2BACK_EN
      exp_rdy = !exp_val || (ordy && exp_q.size() == 1);
`else
      exp_rdy = !exp_val;
`endif
      chk("istream_rdy", {31'd0, istream_rdy}, {31'd0, exp_rdy});
      chk("ostream_val", {31'd0, ostream_val}, {31'd0, exp_val});
      if (exp_val) begin
         chk("cache_req_msg", cache_req_msg, exp_q[0].word);
         chk("ostream_last", {31'd0, ostream_last}, {31'd0, exp_q[0].last});
      end else begin
         chk("ostream_last_idle", {31'd0, ostream_last}, 32'd0);
      end
      if (ostream_val) val_cycles++;
      if (exp_val && ordy) begin
         obs_q.push_back(cache_req_msg);
         xc_q.push_back(cyc);
         void'(exp_q.pop_front());
      end
      if (ival && exp_rdy) begin
         acc_cnt++;
         for (int i = 0; i < NW; i++) begin
            exp_t e;
            e.word = ldata[WB*i +: WB];
            e.last = (i == NW - 1);
            exp_q.push_back(e);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_istream_rdy", {31'd0, istream_rdy}, 32'd0);
      chk("rst_ostream_val", {31'd0, ostream_val}, 32'd0);
      chk("rst_ostream_last", {31'd0, ostream_last}, 32'd0);
      chk("rst_msg", cache_req_msg, 32'd0);
      exp_q.delete();
      obs_q.delete();
      xc_q.delete();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_hold_istream_rdy", {31'd0, istream_rdy}, 32'd0);
      chk("rst_hold_ostream_val", {31'd0, ostream_val}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
   endtask

   function automatic logic pick(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (k % 2 == 0);
      return ($urandom_range(0, 3) != 0);
   endfunction

   // Offer one line until accepted, then drain it; line_data is inverted
   // after acceptance so any late sampling shows up as wrong words.
   task automatic send_line(input logic [LB-1:0] line, input int mode);
      int a0, guard, k;
      a0 = acc_cnt;
      guard = 0;
      while (acc_cnt == a0 && guard < 50) begin
         cycle(1'b1, line, 1'b1);
         guard++;
      end
      k = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         cycle(1'b0, ~line, pick(mode, k));
         k++;
         guard++;
      end
      chk("send_line_timeout", {31'd0, (guard < 200)}, 32'd1);
   endtask

   initial begin
      logic [LB-1:0] la, lb;
      int a0, guard, span;
      reset = 1'b0;
      istream_val = 1'b0;
      ostream_rdy = 1'b0;
      line_data = '0;
      @(negedge clk);
      do_reset();

      // Uniform line of 4s, downstream always ready.
      obs_q.delete();
      send_line(mk_line(32'h4, 32'h0), 0);
      chk("r030_count", obs_q.size(), 32'd16);
      if (obs_q.size() == 16) begin
         chk("r030_w0", obs_q[0], 32'h4);
         chk("r030_w15", obs_q[15], 32'h4);
         chk("r030_consecutive", xc_q[15] - xc_q[0], 32'd15);
      end
      #1;
      chk("r030_rdy_after", {31'd0, istream_rdy}, 32'd1);

      // Low half 1s, high half 4s: word 0 is the low word.
      obs_q.delete(); xc_q.delete();
      la = {{8{32'h4}}, {8{32'h1}}};
      send_line(la, 0);
      if (obs_q.size() == 16) begin
         chk("r031_w0", obs_q[0], 32'h1);
         chk("r031_w7", obs_q[7], 32'h1);
         chk("r031_w8", obs_q[8], 32'h4);
         chk("r031_w15", obs_q[15], 32'h4);
      end else chk("r031_count", obs_q.size(), 32'd16);

      // Index line with ostream_rdy toggling 1/0.
      obs_q.delete(); xc_q.delete();
      val_cycles = 0;
      send_line(mk_line(32'h0, 32'h1), 1);
      chk("r032_count", obs_q.size(), 32'd16);
      for (int i = 0; i < obs_q.size(); i++) chk("r032_word", obs_q[i], 32'(i));
      chk("r032_send_cycles", val_cycles, 32'd31);

      // Words must come from the latched line, not later line_data.
      obs_q.delete(); xc_q.delete();
      send_line(mk_line(32'hA000_0000, 32'h1), 2);
      if (obs_q.size() == 16) chk("r034_w3", obs_q[3], 32'hA000_0003);
      else chk("r034_count", obs_q.size(), 32'd16);

      // Reset after word 5 of line A, then line B.
      la = mk_line(32'h1111_0000, 32'h1);
      lb = mk_line(32'h2222_0000, 32'h1);
      obs_q.delete(); xc_q.delete();
      guard = 0;
      a0 = acc_cnt;
      while (acc_cnt == a0 && guard < 50) begin cycle(1'b1, la, 1'b1); guard++; end
      while (obs_q.size() < 6 && guard < 100) begin cycle(1'b0, la, 1'b1); guard++; end
      chk("r033_a_words", obs_q.size(), 32'd6);
      do_reset();
      send_line(lb, 0);
      chk("r033_count", obs_q.size(), 32'd16);
      if (obs_q.size() == 16) begin
         chk("r033_w0", obs_q[0], 32'h2222_0000);
         chk("r033_w15", obs_q[15], 32'h2222_000F);
      end

      // Two lines offered continuously, downstream always ready.
      obs_q.delete(); xc_q.delete();
      la = mk_line(32'h3333_0000, 32'h1);
      lb = mk_line(32'h4444_0000, 32'h1);
      a0 = acc_cnt;
      guard = 0;
      while (acc_cnt - a0 < 2 && guard < 100) begin
         cycle(1'b1, (acc_cnt == a0) ? la : lb, 1'b1);
         guard++;
      end
      while (exp_q.size() != 0 && guard < 200) begin cycle(1'b0, '0, 1'b1); guard++; end
      chk("r035_count", obs_q.size(), 32'd32);
      if (obs_q.size() == 32) begin
         span = xc_q[31] - xc_q[0] + 1;
         chk("r035_b_w0", obs_q[16], 32'h4444_0000);
`ifdef LAB3_CACHE_MEM_SENDER_BACK2BACK_EN
         chk("r035_span", span, 32'd32);
`else
         chk("r035_span", span, 32'd33);
`endif
      end

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else cycle(1'($urandom_range(0, 1)), rnd_line(), ($urandom_range(0, 3) != 0));
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin cycle(1'b0, '0, 1'b1); guard++; end
      chk("drain_timeout", {31'd0, (exp_q.size() == 0)}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_lab3_cache_cache_mem_sender
